// File: rtl/adder_pkg.sv
// Shared types for the pipelined add/subtract unit: operation select and the
// flag bundle registered alongside the result.
package adder_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    typedef struct packed {
        logic carry;
        logic overflow;
        logic zero;
    } add_flags_t;

endpackage

// File: rtl/add_slice.sv
// One carry-chained slice of the pipelined adder: purely combinational
// SLICE-bit add with carry in and carry out.
module add_slice #(
    parameter int SLICE = 8
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             cin,
    output logic [SLICE-1:0] sum,
    output logic             cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{SLICE{1'b0}}, cin};

endmodule

// File: rtl/pipelined_add_sub.sv
// Pipelined add/subtract: one SLICE-wide carry-chained slice per clock, with
// valid/ready on both sides and registered carry, overflow and zero flags.
module pipelined_add_sub
    import adder_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  op_e              op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             carry,
    output logic             overflow,
    output logic             zero
);

    localparam int SLICE = WIDTH / STAGES;

    if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_params
        $error("pipelined_add_sub: WIDTH must be a multiple of STAGES, 1 <= STAGES <= WIDTH");
    end

    logic              adv;
    logic              accept;
    logic [STAGES-1:0] v_q;

    // Per-stage operand view: index k is what stage k consumes this cycle.
    logic [WIDTH-1:0] a_src [STAGES];
    logic [WIDTH-1:0] b_src [STAGES];
    logic [WIDTH-1:0] r_src [STAGES];
    logic             c_src [STAGES];

    // Skew (upper operand slices), deskew (finished lower result slices) and carry.
    logic [WIDTH-1:0] a_q [STAGES];
    logic [WIDTH-1:0] b_q [STAGES];
    logic [WIDTH-1:0] r_q [STAGES];
    logic             c_q [STAGES];

    logic [WIDTH-1:0] y_q;
    add_flags_t       flags_q;

    // The whole pipe advances in lockstep whenever the output slot can move.
    assign adv       = !v_q[STAGES-1] || out_ready;
    assign in_ready  = adv && !flush && rst_n;
    assign accept    = in_valid && in_ready;
    assign out_valid = v_q[STAGES-1];

    // NOTE: reset is checked before flush so a simultaneous flush cannot mask it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v_q <= '0;
        end else if (flush) begin
            v_q <= '0;
        end else if (adv) begin
            v_q <= (v_q << 1) | STAGES'(accept);
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [SLICE-1:0] sum;
        logic             cout;
        logic [WIDTH-1:0] r_nxt;

        if (k == 0) begin : g_head
            // Subtraction is a + ~b + 1; the +1 enters as the stage-0 carry.
            assign a_src[k] = a;
            assign b_src[k] = (op == OP_SUB) ? ~b : b;
            assign c_src[k] = (op == OP_SUB);
            assign r_src[k] = '0;
        end else begin : g_body
            assign a_src[k] = a_q[k-1];
            assign b_src[k] = b_q[k-1];
            assign c_src[k] = c_q[k-1];
            assign r_src[k] = r_q[k-1];
        end

        add_slice #(.SLICE(SLICE)) u_slice (
            .a    (a_src[k][k*SLICE +: SLICE]),
            .b    (b_src[k][k*SLICE +: SLICE]),
            .cin  (c_src[k]),
            .sum  (sum),
            .cout (cout)
        );

        always_comb begin
            r_nxt                    = r_src[k];
            r_nxt[k*SLICE +: SLICE]  = sum;
        end

        if (k < STAGES - 1) begin : g_pipe
            // NOTE: in-flight data registers carry no reset; their valid bit alone
            // decides whether their contents matter.
            always_ff @(posedge clk) begin
                if (adv) begin
                    a_q[k] <= a_src[k];
                    b_q[k] <= b_src[k];
                    c_q[k] <= cout;
                    r_q[k] <= r_nxt;
                end
            end
        end else begin : g_out
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    y_q     <= '0;
                    flags_q <= '0;
                end else if (adv) begin
                    y_q              <= r_nxt;
                    flags_q.carry    <= cout;
                    flags_q.overflow <= (a_src[k][WIDTH-1] == b_src[k][WIDTH-1]) &&
                                        (r_nxt[WIDTH-1] != a_src[k][WIDTH-1]);
                    flags_q.zero     <= ~|r_nxt;
                end
            end
        end
    end

    assign y        = y_q;
    assign carry    = flags_q.carry;
    assign overflow = flags_q.overflow;
    assign zero     = flags_q.zero;

endmodule

// File: tb/tb_pipelined_add_sub.sv
// Randomised self-checking bench for pipelined_add_sub (32/4, 32/1 and 8/8)
// against an arithmetic reference model.
module tb_pipelined_add_sub;
    import adder_pkg::*;

    typedef struct packed {
        logic [31:0] y;
        logic        c;
        logic        v;
        logic        z;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_valid1 = 1'b0;
    logic        in_valid8 = 1'b0;
    logic        out_ready = 1'b1;
    logic        one = 1'b1;
    logic        nil = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    op_e         op = OP_ADD;

    logic        in_ready, out_valid, carry, overflow, zero;
    logic [31:0] y;
    logic        in_ready1, out_valid1, carry1, overflow1, zero1;
    logic [31:0] y1;
    logic        in_ready8, out_valid8, carry8, overflow8, zero8;
    logic [7:0]  y8;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    pipelined_add_sub #(.WIDTH(32), .STAGES(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
        .y(y), .carry(carry), .overflow(overflow), .zero(zero)
    );

    pipelined_add_sub #(.WIDTH(32), .STAGES(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .flush(nil), .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a), .b(b), .op(op), .out_valid(out_valid1), .out_ready(one),
        .y(y1), .carry(carry1), .overflow(overflow1), .zero(zero1)
    );

    pipelined_add_sub #(.WIDTH(8), .STAGES(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .flush(nil), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a[7:0]), .b(b[7:0]), .op(op), .out_valid(out_valid8), .out_ready(one),
        .y(y8), .carry(carry8), .overflow(overflow8), .zero(zero8)
    );

    // Reference: unsigned and signed integer arithmetic on w-bit operands.
    function automatic exp_t model(input logic [31:0] x, input logic [31:0] z,
                                   input bit sub, input int w);
        longint mask, half, ux, uz, sx, sz, ur, sr;
        exp_t   e;
        mask = (longint'(1) << w) - 1;
        half = longint'(1) << (w - 1);
        ux   = longint'({32'd0, x}) & mask;
        uz   = longint'({32'd0, z}) & mask;
        sx   = (ux >= half) ? ux - (longint'(1) << w) : ux;
        sz   = (uz >= half) ? uz - (longint'(1) << w) : uz;
        ur   = sub ? ux - uz : ux + uz;
        sr   = sub ? sx - sz : sx + sz;
        e.y  = 32'(ur & mask);
        e.c  = sub ? (ux >= uz) : (ur > mask);
        e.v  = (sr > half - 1) || (sr < -half);
        e.z  = ((ur & mask) == 0);
        return e;
    endfunction

    // Presents one beat to the selected instance and waits for its result.
    task automatic run_beat(input int sel, input logic [31:0] x, input logic [31:0] z,
                            input op_e o, output int lat, output exp_t got);
        @(negedge clk);
        a = x; b = z; op = o; out_ready = 1'b1;
        case (sel)
            0:       in_valid  = 1'b1;
            1:       in_valid1 = 1'b1;
            default: in_valid8 = 1'b1;
        endcase
        lat = -1;
        got = '0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            in_valid = 1'b0; in_valid1 = 1'b0; in_valid8 = 1'b0;
            case (sel)
                0: if (out_valid) begin lat = i; got = {y, carry, overflow, zero}; end
                1: if (out_valid1) begin lat = i; got = {y1, carry1, overflow1, zero1}; end
                default: if (out_valid8) begin lat = i; got = {24'd0, y8, carry8, overflow8, zero8}; end
            endcase
            if (lat >= 0) break;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        total++;
        if ({out_valid, y, carry, overflow, zero} !== 36'd0)
            $display("FAIL reset_outputs: got %h expected 0", {out_valid, y, carry, overflow, zero});
        else passed++;
        total++;
        if (in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b expected 0", in_ready);
        else passed++;
        total++;
        if ({out_valid1, out_valid8} !== 2'b00)
            $display("FAIL reset_variants: got %b expected 00", {out_valid1, out_valid8});
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Directed corner cases followed by random operands, one beat at a time.
    task automatic test_single(input int sel, input int w, input int want_lat);
        logic [31:0] x, z;
        op_e         o;
        int          lat;
        exp_t        got, e;
        for (int i = 0; i < 8; i++) begin
            case (i)
                0: begin x = 32'h1;         z = 32'h2; o = OP_ADD; end
                1: begin x = 32'hFFFF_FFFF; z = 32'h1; o = OP_ADD; end
                2: begin x = (w == 8) ? 32'h7F : 32'h7FFF_FFFF; z = 32'h1; o = OP_ADD; end
                3: begin x = 32'h5;         z = 32'h7; o = OP_SUB; end
                4: begin x = (w == 8) ? 32'h80 : 32'h8000_0000; z = 32'h1; o = OP_SUB; end
                default: begin x = $urandom; z = $urandom; o = op_e'($urandom_range(0, 1)); end
            endcase
            e = model(x, z, o == OP_SUB, w);
            run_beat(sel, x, z, o, lat, got);
            total++;
            if (lat !== want_lat)
                $display("FAIL latency_s%0d_%0d: got %0d expected %0d", sel, i, lat, want_lat);
            else passed++;
            total++;
            if (got !== e)
                $display("FAIL result_s%0d_%0d: got y=%h c=%b v=%b z=%b expected y=%h c=%b v=%b z=%b",
                         sel, i, got.y, got.c, got.v, got.z, e.y, e.c, e.v, e.z);
            else passed++;
        end
    endtask

    task automatic test_back_to_back;
        exp_t        q[$];
        exp_t        e;
        logic [31:0] pa = '0, pb = '0, held_y = '0;
        op_e         po = OP_ADD;
        bit          need_new = 1'b1, stalled = 1'b0;
        int          sent = 0, received = 0, stall_seen = 0;
        for (int cyc = 0; cyc < 80 && received < 8; cyc++) begin
            @(negedge clk);
            out_ready = !(cyc >= 6 && cyc <= 8);
            if (sent < 8) begin
                if (need_new) begin
                    pa = $urandom; pb = $urandom; po = op_e'($urandom_range(0, 1));
                    need_new = 1'b0;
                end
                a = pa; b = pb; op = po; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (out_valid && !out_ready) begin
                stall_seen++;
                total++;
                if (in_ready !== 1'b0) $display("FAIL stall_in_ready: got %b expected 0", in_ready);
                else passed++;
                if (stalled) begin
                    total++;
                    if (y !== held_y) $display("FAIL stall_hold: got %h expected %h", y, held_y);
                    else passed++;
                end
                held_y  = y;
                stalled = 1'b1;
            end else begin
                stalled = 1'b0;
            end
            if (out_valid && out_ready) begin
                total++;
                if (q.size() == 0) begin
                    $display("FAIL b2b_extra: got y=%h expected no result", y);
                end else begin
                    e = q.pop_front();
                    if ({y, carry, overflow, zero} !== e)
                        $display("FAIL b2b_result_%0d: got %h expected %h", received,
                                 {y, carry, overflow, zero}, e);
                    else passed++;
                end
                received++;
            end
            if (in_valid && in_ready) begin
                q.push_back(model(pa, pb, po == OP_SUB, 32));
                sent++;
                need_new = 1'b1;
            end
        end
        in_valid = 1'b0;
        total++;
        if (received != 8 || q.size() != 0)
            $display("FAIL b2b_count: got %0d results, %0d pending expected 8, 0", received, q.size());
        else passed++;
        total++;
        if (stall_seen != 3) $display("FAIL b2b_stall_cycles: got %0d expected 3", stall_seen);
        else passed++;
    endtask

    task automatic test_flush;
        int   lat;
        exp_t got, e;
        bit   seen = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            a = $urandom; b = $urandom; op = OP_ADD; in_valid = 1'b1;
        end
        @(negedge clk);
        a = 32'h1234_5678; b = 32'h1; flush = 1'b1; in_valid = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b0) $display("FAIL flush_in_ready: got %b expected 0", in_ready);
        else passed++;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (out_valid) seen = 1'b1;
            @(negedge clk);
        end
        total++;
        if (seen !== 1'b0) $display("FAIL flush_drop: got out_valid=1 expected none");
        else passed++;
        e = model(32'hDEAD_BEEF, 32'h0101_0101, 1'b1, 32);
        run_beat(0, 32'hDEAD_BEEF, 32'h0101_0101, OP_SUB, lat, got);
        total++;
        if (lat !== 4 || got !== e)
            $display("FAIL flush_recover: got lat=%0d %h expected lat=4 %h", lat, got, e);
        else passed++;
    endtask

    task automatic test_reset_mid;
        int   lat;
        exp_t got, e;
        bit   seen = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            a = $urandom | 32'h1; b = $urandom; op = OP_ADD; in_valid = 1'b1;
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++;
        if (in_ready !== 1'b0) $display("FAIL rst_mid_in_ready: got %b expected 0", in_ready);
        else passed++;
        @(negedge clk);
        rst_n = 1'b1; in_valid = 1'b0;
        #1;
        total++;
        if ({out_valid, y, carry, overflow, zero} !== 36'd0)
            $display("FAIL rst_mid_clear: got %h expected 0", {out_valid, y, carry, overflow, zero});
        else passed++;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b0) $display("FAIL rst_mid_discard: got out_valid=1 expected none");
        else passed++;
        e = model(32'h0000_0010, 32'hFFFF_FFF0, 1'b0, 32);
        run_beat(0, 32'h0000_0010, 32'hFFFF_FFF0, OP_ADD, lat, got);
        total++;
        if (lat !== 4 || got !== e)
            $display("FAIL rst_mid_recover: got lat=%0d %h expected lat=4 %h", lat, got, e);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_single(0, 32, 4);
        test_back_to_back();
        test_flush();
        test_reset_mid();
        test_single(1, 32, 1);
        test_single(2, 8, 8);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
